// File: rtl/eig_pkg.sv
// Shared constants and state encodings for the eigenvector datapath.
package eig_pkg;

    localparam int unsigned DW   = 4;
    localparam int unsigned N    = 4;
    localparam int unsigned ACCW = 10;
    localparam int unsigned IDXW = $clog2(N);

    typedef enum logic [1:0] {
        MV_IDLE = 2'd0,
        MV_RUN  = 2'd1,
        MV_DONE = 2'd2
    } mv_state_e;

endpackage

// File: rtl/matvec_mac_cell.sv
// Single multiply-accumulate lane: registered accumulator with clear/enable.
module matvec_mac_cell
    import eig_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clr,
    input  logic            i_en,
    input  logic [DW-1:0]   i_a,
    input  logic [DW-1:0]   i_b,
    output logic [ACCW-1:0] o_acc,
    output logic [ACCW-1:0] o_acc_next
);

    logic [2*DW-1:0] w_prod;
    logic [ACCW-1:0] r_acc;

    assign w_prod     = i_a * i_b;
    assign o_acc_next = r_acc + {{(ACCW - 2*DW){1'b0}}, w_prod};
    assign o_acc      = r_acc;

    // Accumulator: clear wins over enable so a row boundary always restarts at zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= o_acc_next;
        end
    end

endmodule

// File: rtl/matvec_mac_unit.sv
// Sequential 4x4 matrix-vector multiplier, one MAC per cycle, with max tracking.
module matvec_mac_unit
    import eig_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [N*N*DW-1:0]     a_flat,
    input  logic [N*DW-1:0]       v_in,
    output logic                  busy,
    output logic                  done,
    output logic [N*ACCW-1:0]     y_out,
    output logic [ACCW-1:0]       y_max,
    output logic [IDXW-1:0]       y_max_idx,
    output logic                  y_zero
);

    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    mv_state_e           r_state;
    logic [N*N*DW-1:0]   r_a;
    logic [N*DW-1:0]     r_v;
    logic [IDXW-1:0]     r_row;
    logic [IDXW-1:0]     r_col;
    logic [N*ACCW-1:0]   r_y_shadow;
    logic [ACCW-1:0]     r_run_max;
    logic [IDXW-1:0]     r_run_idx;
    logic                r_busy;
    logic                r_done;
    logic [N*ACCW-1:0]   r_y_out;
    logic [ACCW-1:0]     r_y_max;
    logic [IDXW-1:0]     r_y_max_idx;
    logic                r_y_zero;

    logic [DW-1:0]       w_a_elem;
    logic [DW-1:0]       w_v_elem;
    logic                w_row_end;
    logic                w_clr;
    logic                w_en;
    logic [ACCW-1:0]     w_acc;
    logic [ACCW-1:0]     w_acc_next;
    logic [N*ACCW-1:0]   w_y_shadow_next;
    logic [ACCW-1:0]     w_max_next;
    logic [IDXW-1:0]     w_idx_next;

    assign w_a_elem  = r_a[(N * 32'(r_row) + 32'(r_col)) * DW +: DW];
    assign w_v_elem  = r_v[32'(r_col) * DW +: DW];
    assign w_row_end = (r_state == MV_RUN) && (r_col == LAST);
    assign w_en      = (r_state == MV_RUN);
    assign w_clr     = ((r_state == MV_IDLE) && start) || w_row_end;

    matvec_mac_cell u_cell (
        .i_clk      (clk),
        .i_rst      (reset),
        .i_clr      (w_clr),
        .i_en       (w_en),
        .i_a        (w_a_elem),
        .i_b        (w_v_elem),
        .o_acc      (w_acc),
        .o_acc_next (w_acc_next)
    );

    // Row-completion view: shadow/max as they will be after this edge (strict > keeps lower index).
    always_comb begin
        w_y_shadow_next = r_y_shadow;
        w_max_next      = r_run_max;
        w_idx_next      = r_run_idx;
        if (w_row_end) begin
            w_y_shadow_next[32'(r_row) * ACCW +: ACCW] = w_acc_next;
            if (w_acc_next > r_run_max) begin
                w_max_next = w_acc_next;
                w_idx_next = r_row;
            end
        end
    end

    // Control FSM, counters, snapshot and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= MV_IDLE;
            r_a         <= '0;
            r_v         <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_y_shadow  <= '0;
            r_run_max   <= '0;
            r_run_idx   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_y_out     <= '0;
            r_y_max     <= '0;
            r_y_max_idx <= '0;
            r_y_zero    <= 1'b1;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                MV_IDLE: begin
                    if (start) begin
                        r_a       <= a_flat;
                        r_v       <= v_in;
                        r_row     <= '0;
                        r_col     <= '0;
                        r_run_max <= '0;
                        r_run_idx <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= MV_RUN;
                    end
                end
                MV_RUN: begin
                    r_y_shadow <= w_y_shadow_next;
                    r_run_max  <= w_max_next;
                    r_run_idx  <= w_idx_next;
                    if (r_col == LAST) begin
                        r_col <= '0;
                        if (r_row == LAST) begin
                            r_state     <= MV_DONE;
                            r_done      <= 1'b1;
                            r_y_out     <= w_y_shadow_next;
                            r_y_max     <= w_max_next;
                            r_y_max_idx <= w_idx_next;
                            r_y_zero    <= (w_y_shadow_next == '0);
                        end else begin
                            r_row <= r_row + 1'b1;
                        end
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                MV_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= MV_IDLE;
                end
                default: r_state <= MV_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign y_out     = r_y_out;
    assign y_max     = r_y_max;
    assign y_max_idx = r_y_max_idx;
    assign y_zero    = r_y_zero;

    // Accumulator value itself is only observed through o_acc_next.
    logic w_unused;
    assign w_unused = ^w_acc;

endmodule

// File: doc/matvec_mac_unit.md
Name: matvec_mac_unit

Overview:
- Sequential 4x4 matrix-vector multiplier for the power-iteration eigenvector engine. Computes y = A·v using one multiply-accumulate per cycle.
- Sits between the matrix/seed editing front end and the scale/normalise stage of the dominant-eigenvector datapath.
- Consumes the packed matrix and vector plus a start pulse. Produces the y vector, its maximum element and index, and a one-cycle done pulse.

Parameters:
- DW, 4, bit width of each matrix and vector element (unsigned).
- N, 4, matrix dimension; the row and column counter width is clog2(N).
- ACCW, 10, accumulator and output element width; must be at least 2*DW+clog2(N).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- a_flat  in  N*N*DW  row-major packed matrix; element [r][c] at bits ((N*r+c)*DW) +: DW.
- v_in  in  N*DW  packed vector; element c at bits (c*DW) +: DW.
- busy  out  1  high from the cycle after start is accepted until done, inclusive.
- done  out  1  one-cycle pulse; y_out, y_max and y_max_idx become valid on this cycle.
- y_out  out  N*ACCW  packed result; element r at bits (r*ACCW) +: ACCW.
- y_max  out  ACCW  largest element of y.
- y_max_idx  out  clog2(N)  index of y_max.
- y_zero  out  1  high when every y element is 0.

Behaviour:
- Reset is asynchronous and active-high. It forces:
  - state to IDLE, counters to 0, accumulator to 0;
  - busy=0, done=0, y_out=0, y_max=0, y_max_idx=0, y_zero=1.
- Reset mid-run discards the computation. No done pulse is produced.
- States: IDLE, RUN, DONE (encodings defined in the package).
- IDLE:
  - start=1 snapshots a_flat and v_in into internal registers.
  - Clears row=0, col=0, acc=0, run_max=0, run_idx=0.
  - Next state is RUN.
- RUN:
  - Each cycle: acc_next = acc + A[row][col]*v[col]. Product is zero-extended DW*2 to ACCW.
  - col < N-1: acc <= acc_next; col increments.
  - col = N-1:
    - acc_next is written to shadow y[row]; acc clears; col wraps to 0.
    - If acc_next > run_max (strictly greater), run_max and run_idx update. Ties keep the lower index.
    - If row = N-1, next state is DONE; otherwise row increments.
- DONE (one cycle):
  - done=1.
  - Shadow y, run_max, run_idx and the zero flag are copied to the outputs in the same edge that enters DONE, so outputs are valid while done=1.
  - Next state is IDLE.
- Latency: start sampled at edge 0 → done high in cycle N*N+1 (17 for N=4). busy is high for 17 cycles.
- Outputs hold their last values until the next DONE. They are never partially updated mid-run.
- start in RUN or DONE is ignored, with no queueing. start in the cycle after DONE (IDLE) is accepted.
- Changes to a_flat or v_in after the start cycle do not affect the current result.
- No overflow is possible with default widths: the maximum is 15*15*4 = 900 < 1024.

Decomposition:
- Shared package eig_pkg holds:
  - DW, N, ACCW constants;
  - state encodings MV_IDLE, MV_RUN, MV_DONE;
  - index-width helper constant IDXW = clog2(N).
- One natural sub-module: matvec_mac_cell. It holds the registered accumulator with clear/enable and the combinational DW×DW multiply plus ACCW add. The FSM, counters, snapshot, max tracking and output registers stay in matvec_mac_unit.

Test Plan:
- Reset defaults: A diag 4, off-diag 1; v all 1; pulse start → done exactly 17 cycles later. y_out = {7,7,7,7}, y_max=7, y_max_idx=0, y_zero=0, busy high 17 cycles.
- Saturation: all A=15, v=15 → every y=900, y_max=900, idx=0. No overflow.
- Distinct rows and tie-break:
  - A rows {1,0,0,0}, {0,2,0,0}, {0,0,3,0}, {0,0,0,3}; v={5,5,5,5} → y={5,10,15,15}, y_max=15, y_max_idx=2.
  - v all 0 → y=0, y_zero=1, y_max_idx=0.
- Start while busy and input isolation:
  - Pulse start again at cycle 5 → still exactly one done at cycle 17.
  - Change a_flat and v_in at cycle 3 → result matches the snapshot values.
- Back-to-back: start in the cycle after done → second done 17 cycles later with new results. Outputs hold the first results until then.
- Async reset mid-run: assert reset at cycle 8, between clock edges → all outputs are defaults immediately and no done pulse occurs. A new start after release completes normally.
